// File: rtl/cmp_sweep_ctrl.sv
// cmp_sweep_ctrl: sweeps every (A,B) operand pair through an external comparator and tallies flag mismatches.
module cmp_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [2:0]       flags_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic             err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b
);
  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [2:0] expect_flags;
  logic       mismatch, last;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  always_comb begin
    expect_flags = {a_out > b_out, a_out == b_out, a_out < b_out};
    mismatch     = flags_in != expect_flags;
    last         = &a_out && &b_out;
    state_nxt    = !enable         ? state :
                   state == IDLE   ? (start ? WAIT : IDLE) :
                   state == WAIT   ? (cnt == 4'd1 ? CHECK : WAIT) :
                   state == CHECK  ? (last ? DONE : WAIT) : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
  end
  // done is a registered pulse, so a freeze while sitting in DONE drops it after one cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_out       <= '0;
      b_out       <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      err_valid   <= 1'b0;
      first_err_a <= '0;
      first_err_b <= '0;
    end else if (!enable) begin
      done <= 1'b0;
    end else begin
      done <= state == CHECK && last;
      if (state == IDLE && start) begin
        a_out       <= '0;
        b_out       <= '0;
        cnt         <= 4'(SETTLE);
        pass        <= 1'b0;
        err_count   <= '0;
        err_valid   <= 1'b0;
        first_err_a <= '0;
        first_err_b <= '0;
      end
      if (state == WAIT) cnt <= cnt - 4'd1;
      if (state == CHECK) begin
        if (mismatch) err_count <= &err_count ? err_count : err_count + 8'd1;
        if (mismatch && !err_valid) begin
          err_valid   <= 1'b1;
          first_err_a <= a_out;
          first_err_b <= b_out;
        end
        if (last) pass <= err_count == 8'd0 && !mismatch;
        else begin
          a_out <= a_out + 1'b1;
          b_out <= &a_out ? b_out + 1'b1 : b_out;
          cnt   <= 4'(SETTLE);
        end
      end
    end
endmodule

// File: tb/tb_cmp_sweep_ctrl.sv
// tb_cmp_sweep_ctrl: randomized and directed sweeps checked against a pair-level reference model.
module tb_cmp_sweep_ctrl;
  localparam int W = 4, S = 2, NP = 256, TOT = (S + 1) * NP;
  logic clk = 0, reset = 1, enable = 0, start = 0;
  logic [W-1:0] a_out, b_out, first_err_a, first_err_b;
  logic [2:0] flags_in;
  logic busy, done, pass, err_valid;
  logic [7:0] err_count;
  logic [2:0] tab [NP];
  int cum [NP+1];
  int first_p;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  cmp_sweep_ctrl #(.WIDTH(W), .SETTLE(S)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .a_out(a_out), .b_out(b_out), .flags_in(flags_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .err_valid(err_valid), .first_err_a(first_err_a), .first_err_b(first_err_b)
  );
  always_comb flags_in = tab[{b_out, a_out}];
  function automatic logic [2:0] cmp3(int a, int b);
    return {a > b, a == b, a < b};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_a"}, a_out, 0);
    check({tag, "_b"}, b_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_errc"}, err_count, 0);
    check({tag, "_errv"}, err_valid, 0);
    check({tag, "_fa"}, first_err_a, 0);
    check({tag, "_fb"}, first_err_b, 0);
  endtask
  // comparator behaviour per pair (index = b*16+a, i.e. sweep order) and its mismatch prefix sums
  task automatic load(input int mode);
    first_p = -1;
    cum[0] = 0;
    for (int p = 0; p < NP; p++) begin
      logic [2:0] g;
      g = cmp3(p % 16, p / 16);
      tab[p] = mode == 0 ? g : mode == 1 ? 3'b010 : mode == 2 ? 3'b000 :
               ($urandom_range(0, 7) == 0 ? 3'($urandom) : g);
      cum[p+1] = cum[p] + int'(tab[p] != g);
      if (tab[p] != g && first_p < 0) first_p = p;
    end
  endtask
  task automatic run(input int mode, input int gap_at, input int gap_len, input int rst_at, input bit repulse);
    int n, p, ce;
    bit en;
    n = -1;
    load(mode);
    for (int t = 0; t < 2000 && n < TOT + 2; t++) begin
      @(negedge clk);
      en = !(t > gap_at && t <= gap_at + gap_len);
      enable = en;
      start = (t == 0) || (repulse && (t == 10 || t == 500));
      if (t == rst_at) begin
        #2 reset = 1;
        #1 check_idle("rst_async");
        @(posedge clk);
        #1 check_idle("rst_hold");
        @(negedge clk);
        reset = 0;
        start = 0;
        for (int k = 0; k < 20; k++) begin
          @(posedge clk);
          #1 check("post_rst_done", done, 0);
          check("post_rst_busy", busy, 0);
        end
        return;
      end
      @(posedge clk);
      if (en) n++;
      #1;
      p = n / 3 > NP - 1 ? NP - 1 : n / 3;
      ce = cum[n / 3 > NP ? NP : n / 3];
      check("a", a_out, p % 16);
      check("b", b_out, p / 16);
      check("busy", busy, n <= TOT);
      check("done", done, en && n == TOT);
      check("pass", pass, n >= TOT && cum[NP] == 0);
      check("err_count", err_count, ce > 255 ? 255 : ce);
      check("err_valid", err_valid, ce > 0);
      check("first_a", first_err_a, ce > 0 ? first_p % 16 : 0);
      check("first_b", first_err_b, ce > 0 ? first_p / 16 : 0);
    end
    check("sweep_completed", n >= TOT + 2, 1);
    start = 0;
    enable = 1;
  endtask
  initial begin
    #12 check_idle("init");
    @(negedge clk);
    reset = 0;
    enable = 1;
    run(0, 0, 0, -1, 0);
    run(1, 0, 0, -1, 0);
    run(2, 0, 0, -1, 0);
    run(0, 100, 50, -1, 0);
    run(0, 0, 0, 300, 0);
    run(0, 0, 0, -1, 0);
    run(0, 0, 0, -1, 1);
    run(3, 767, 5, -1, 0);
    for (int i = 0; i < 4; i++)
      run(3, $urandom_range(0, 800), $urandom_range(0, 40), -1, 1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cmp_sweep_ctrl.md
CMP_SWEEP_CTRL -- requirements
Module: cmp_sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: operand width driven to the comparator under test.
REQ-002 Parameter SETTLE, default 2, legal range 1..15: cycles waited after each operand change before the flags are sampled.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port enable, input, 1: high = block advances; low = all state held.
REQ-006 Port start, input, 1: begin a sweep; sampled only in IDLE.
REQ-007 Port a_out, output, WIDTH: operand A to the comparator.
REQ-008 Port b_out, output, WIDTH: operand B to the comparator.
REQ-009 Port flags_in, input, 3: comparator result {gt, eq, lt}; legal values are one-hot only.
REQ-010 Port busy, output, 1: high in every state except IDLE.
REQ-011 Port done, output, 1: one-cycle pulse at sweep end.
REQ-012 Port pass, output, 1: high when the last sweep had zero errors; held until the next start.
REQ-013 Port err_count, output, 8: mismatch count, saturating at 255.
REQ-014 Port err_valid, output, 1: high once the first mismatch of the sweep is captured.
REQ-015 Port first_err_a, output, WIDTH: operand A of the first mismatch.
REQ-016 Port first_err_b, output, WIDTH: operand B of the first mismatch.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, WAIT, CHECK and DONE.
REQ-018 IDLE, start=1 and enable=1 SHALL:
- set a_out=0 and b_out=0;
- clear err_count, err_valid, first_err_a and first_err_b;
- clear pass;
- load the settle counter with SETTLE;
- enter WAIT.
REQ-019 WAIT SHALL last exactly SETTLE enabled cycles, then enter CHECK.
REQ-020 CHECK SHALL compute the expected flags from a_out and b_out (unsigned): gt=(A>B), eq=(A==B), lt=(A<B).
REQ-021 A mismatch SHALL be flags_in != expected; any non-one-hot flags_in SHALL count as a mismatch.
REQ-022 On a mismatch, err_count SHALL increment unless it is already 255.
REQ-023 On a mismatch with err_valid=0, the block SHALL capture a_out and b_out into first_err_a and first_err_b and set err_valid.
REQ-024 CHECK with a_out and b_out both all-ones SHALL enter DONE.
REQ-025 Otherwise CHECK SHALL:
- increment a_out;
- on a_out wrapping from all-ones to 0, also increment b_out;
- reload the settle counter with SETTLE;
- enter WAIT.
REQ-026 Sweep order SHALL be A-fastest: (0,0), (1,0) ... (max,0), (0,1) ... (max,max).
REQ-027 Each operand pair SHALL occupy exactly SETTLE+1 enabled cycles.
REQ-028 DONE SHALL last one cycle: done=1, pass=(err_count==0 after the final CHECK), then return to IDLE.
REQ-029 With WIDTH=4 and SETTLE=2, done SHALL rise exactly 768 enabled cycles after the start cycle.
REQ-030 enable=0 SHALL freeze the state, both operands, the settle counter and all status outputs; done SHALL stay 0 while frozen.
REQ-031 start outside IDLE SHALL be ignored.
REQ-032 start=1 with enable=0 in IDLE SHALL be ignored.
REQ-033 a_out and b_out SHALL remain stable throughout WAIT and CHECK.
REQ-034 After DONE, a_out and b_out SHALL hold all-ones.
REQ-035 All outputs SHALL be registered; no output SHALL depend combinationally on an input.

Reset
REQ-036 While reset=1, independent of clk and enable, the block SHALL force:
- state=IDLE;
- a_out=0 and b_out=0;
- busy=0, done=0 and pass=0;
- err_count=0 and err_valid=0;
- first_err_a=0 and first_err_b=0;
- settle counter=0.
REQ-037 Reset asserted mid-sweep SHALL abort the sweep with no done pulse.
REQ-038 After reset releases, the block SHALL wait in IDLE for a new start.

Verification
REQ-039 The bench SHALL cover the following directed scenarios (WIDTH=4, SETTLE=2):
- V1 golden comparator on flags_in, one start pulse -> done pulse at cycle 768; pass=1; err_count=0; err_valid=0.
- V2 flags_in stuck at 3'b010 (eq) -> err_count=240; first_err_a=1, first_err_b=0; pass=0.
- V3 flags_in stuck at 3'b000 -> err_count saturates at 255; err_valid=1; first_err=(0,0).
- V4 enable low for 50 cycles at cycle 100 -> all outputs frozen during the gap; done lands at cycle 818; pass=1.
- V5 reset pulse at cycle 300 -> immediate IDLE with all outputs zero; no done; a later start completes a normal sweep.
- V6 start re-pulsed at cycles 10 and 500 while busy -> ignored; exactly one done at cycle 768.
